// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO. Everything runs in the xipMCLK domain.
// xopTXD idles high. Queued bytes are sent back-to-back with no gap between frames.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV = 87,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic       xipMCLK,
  input  logic       xinRESET,
  input  logic       xipWR_EN,
  input  logic [7:0] xipWR_DATA,
  input  logic       xipOVF_CLR,
  output logic       xopFULL,
  output logic       xopEMPTY,
  output logic       xopOVERFLOW,
  output logic       xopBUSY,
  output logic       xopTXD
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ZERO  = FIFO_AW'(0);
  localparam logic [FIFO_AW:0]   CNT_ONE   = CW'(1);
  localparam logic [FIFO_AW:0]   CNT_ZERO  = CW'(0);
  localparam logic [FIFO_AW:0]   CNT_DEPTH = CW'(DEPTH);
  localparam logic [15:0]        BAUD_LAST = 16'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
  logic [1:0]         state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d, busy_q, busy_d;
  logic               wr_accept_s, pop_s, baud_end_s;

  assign wr_accept_s = xipWR_EN & ~full_q;
  assign baud_end_s  = (baud_q == BAUD_LAST);

  // Frame sequencer: the next TXD level is computed together with the state, so the pin is a flop.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = 16'd0;
        bit_d  = 3'd0;
        if (!empty_q) begin
          pop_s   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          txd_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          baud_d = 16'd0;
          bit_d  = 3'd0;
          // Chain straight into the next start bit when more data is waiting.
          if (!empty_q) begin
            pop_s   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
        txd_d   = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // FIFO bookkeeping. A pop only happens when the FIFO is non-empty, so the count never underflows.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_DEPTH);
    empty_d = (count_d == CNT_ZERO);
    if (xipWR_EN && full_q) begin
      ovf_d = 1'b1;
    end else if (xipOVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage; it needs no reset because the pointers define which entries are valid.
  always_ff @(posedge xipMCLK) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_q] <= xipWR_DATA;
    end
  end

  // State registers.
  always_ff @(posedge xipMCLK or negedge xinRESET) begin
    if (!xinRESET) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
    end
  end

  assign xopFULL     = full_q;
  assign xopEMPTY    = empty_q;
  assign xopOVERFLOW = ovf_q;
  assign xopBUSY     = busy_q;
  assign xopTXD      = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo. dut_a uses a short baud divider and a 4-deep FIFO.
// dut_b uses the default parameters and is used for the bit-period timing check.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic       rst_a, wr_a, clr_a;
  logic [7:0] data_a;
  logic       full_a, empty_a, ovf_a, busy_a, txd_a;
  logic       rst_b, wr_b, clr_b;
  logic [7:0] data_b;
  logic       full_b, empty_b, ovf_b, busy_b, txd_b;

  uart_tx_fifo #(.CLK_DIV(4), .FIFO_AW(2)) dut_a (
    .xipMCLK(clk), .xinRESET(rst_a), .xipWR_EN(wr_a), .xipWR_DATA(data_a),
    .xipOVF_CLR(clr_a), .xopFULL(full_a), .xopEMPTY(empty_a),
    .xopOVERFLOW(ovf_a), .xopBUSY(busy_a), .xopTXD(txd_a)
  );

  uart_tx_fifo dut_b (
    .xipMCLK(clk), .xinRESET(rst_b), .xipWR_EN(wr_b), .xipWR_DATA(data_b),
    .xipOVF_CLR(clr_b), .xopFULL(full_b), .xopEMPTY(empty_b),
    .xopOVERFLOW(ovf_b), .xopBUSY(busy_b), .xopTXD(txd_b)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line level per bit period, bit 0 = start bit
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic       mon_txd   [0:1023];
  logic       mon_busy  [0:1023];
  logic       mon_empty [0:1023];
  int         mon_n = 0;
  logic       mon_en = 1'b0;
  logic [9:0] exp_fr [0:7];
  vec_t       vecs [0:4];

  // Capture dut_a outputs once per cycle, on the falling edge.
  always @(negedge clk) begin
    if (mon_en && mon_n < 1024) begin
      mon_txd[mon_n]   = txd_a;
      mon_busy[mon_n]  = busy_a;
      mon_empty[mon_n] = empty_a;
      mon_n = mon_n + 1;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_a   = 1'b1;
    data_a = d;
    tick(1);
    wr_a   = 1'b0;
  endtask

  task automatic mon_start();
    mon_n  = 0;
    mon_en = 1'b1;
  endtask

  // Compare the captured line against nfr back-to-back frames in exp_fr, starting at sample 2.
  task automatic check_stream(input string nm, input int nfr);
    int s, glitch, busy_n, low_tail;
    logic [9:0] got;
    mon_en = 1'b0;
    s = -1;
    for (int i = 0; i < mon_n; i++) begin
      if (s < 0 && !mon_txd[i]) s = i;
    end
    check({nm, " start sample"}, s, 2);
    if (s < 0 || s > 8) s = 2;
    for (int k = 0; k < nfr; k++) begin
      got = '0;
      for (int b = 0; b < 10; b++) got[b] = mon_txd[s + k*40 + b*4 + 2];
      check($sformatf("%s frame%0d bits", nm, k), int'(got), int'(exp_fr[k]));
    end
    glitch = 0;
    for (int i = s; i < s + nfr*40; i++) begin
      if (mon_txd[i] !== mon_txd[s + ((i - s) / 4) * 4 + 2]) glitch++;
    end
    check({nm, " bit-hold glitches"}, glitch, 0);
    busy_n = 0;
    for (int i = 0; i < mon_n; i++) if (mon_busy[i]) busy_n++;
    check({nm, " busy cycles"}, busy_n, nfr*40);
    low_tail = 0;
    for (int i = s + nfr*40; i < mon_n; i++) if (!mon_txd[i]) low_tail++;
    check({nm, " idle after frames"}, low_tail, 0);
  endtask

  initial begin
    time  t_prev, t_now;
    logic lvl;
    bit   ok;
    int   low_n, busy_n;

    vecs[0] = '{data: 8'hA5, frame: 10'b1_10100101_0};
    vecs[1] = '{data: 8'h3C, frame: 10'b1_00111100_0};
    vecs[2] = '{data: 8'h00, frame: 10'b1_00000000_0};
    vecs[3] = '{data: 8'hFF, frame: 10'b1_11111111_0};
    vecs[4] = '{data: 8'h81, frame: 10'b1_10000001_0};

    rst_a = 1'b0; wr_a = 1'b0; clr_a = 1'b0; data_a = 8'h00;
    rst_b = 1'b0; wr_b = 1'b0; clr_b = 1'b0; data_b = 8'h00;
    tick(2);
    check("reset txd",   int'(txd_a),   1);
    check("reset busy",  int'(busy_a),  0);
    check("reset full",  int'(full_a),  0);
    check("reset empty", int'(empty_a), 1);
    check("reset ovf",   int'(ovf_a),   0);
    check("reset txd_b", int'(txd_b),   1);
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick(2);

    // Single-byte frames from the vector table.
    for (int v = 0; v < 5; v++) begin
      exp_fr[0] = vecs[v].frame;
      mon_start();
      push(vecs[v].data);
      tick(48);
      check_stream($sformatf("vec%0d", v), 1);
      check($sformatf("vec%0d empty after write", v), int'(mon_empty[1]), 0);
      check($sformatf("vec%0d empty at pop", v),      int'(mon_empty[2]), 1);
    end

    // Burst of three bytes on consecutive cycles.
    exp_fr[0] = 10'b1_00000000_0;
    exp_fr[1] = 10'b1_11111111_0;
    exp_fr[2] = 10'b1_01010101_0;
    mon_start();
    push(8'h00); push(8'hFF); push(8'h55);
    tick(128);
    check_stream("burst", 3);

    // Overfill, overflow clear, a drop at a full-FIFO pop, and a write that coincides with a pop.
    exp_fr[0] = 10'b1_00010001_0;
    exp_fr[1] = 10'b1_00100010_0;
    exp_fr[2] = 10'b1_00110011_0;
    exp_fr[3] = 10'b1_01000100_0;
    exp_fr[4] = 10'b1_01010101_0;
    exp_fr[5] = 10'b1_10001000_0;
    mon_start();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("fill full after 5th", int'(full_a), 1);
    check("fill ovf before 6th", int'(ovf_a),  0);
    push(8'h66);
    check("fill ovf after 6th",  int'(ovf_a),  1);
    check("fill full after 6th", int'(full_a), 1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("ovf cleared", int'(ovf_a), 0);
    tick(34);
    push(8'h77);
    check("drop at full pop ovf",  int'(ovf_a),  1);
    check("drop at full pop full", int'(full_a), 0);
    tick(39);
    push(8'h88);
    check("pop+write full",  int'(full_a),  0);
    check("pop+write empty", int'(empty_a), 0);
    check("ovf sticky",      int'(ovf_a),   1);
    tick(170);
    check_stream("fill", 6);
    check("fill drained empty", int'(empty_a), 1);

    // Asynchronous reset in the middle of a data bit with two bytes still queued.
    push(8'h3C); push(8'hAA); push(8'hBB);
    tick(5);
    #20;
    check("pre-reset txd",  int'(txd_a),  0);
    check("pre-reset busy", int'(busy_a), 1);
    rst_a = 1'b0;
    #1;
    check("async reset txd",   int'(txd_a),   1);
    check("async reset busy",  int'(busy_a),  0);
    check("async reset empty", int'(empty_a), 1);
    check("async reset full",  int'(full_a),  0);
    #30;
    rst_a = 1'b1;
    mon_start();
    tick(60);
    mon_en = 1'b0;
    low_n = 0;
    busy_n = 0;
    for (int i = 0; i < mon_n; i++) begin
      if (!mon_txd[i]) low_n++;
      if (mon_busy[i]) busy_n++;
    end
    check("post-reset txd low cycles", low_n, 0);
    check("post-reset busy cycles",    busy_n, 0);
    check("post-reset empty", int'(empty_a), 1);

    // Default divider: every bit of 0x55 must last 87 MCLK periods.
    wr_b   = 1'b1;
    data_b = 8'h55;
    tick(1);
    wr_b   = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (!txd_b) ok = 1'b1;
    end
    check("dflt start seen", int'(ok), 1);
    t_prev = $time;
    lvl = 1'b0;
    for (int i = 1; i < 10; i++) begin
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        if (txd_b != lvl) ok = 1'b1;
      end
      t_now = $time;
      check($sformatf("dflt period%0d ns", i - 1), ok ? int'(t_now - t_prev) : -1, 8700);
      t_prev = t_now;
      lvl = ~lvl;
    end
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (!busy_b) ok = 1'b1;
    end
    t_now = $time;
    check("dflt stop period ns", ok ? int'(t_now - t_prev) : -1, 8700);
    check("dflt idle txd", int'(txd_b), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
